// File: rtl/addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// addsub_pipe_if
// Operand/result bundle for the pipelined add/subtract unit.
//   in_valid/in_ready : operand beat handshake (a, b, op, cin)
//   out_valid/out_ready : result handshake (sum, cout, overflow, zero, negative)
// modport slave  : the adder pipeline
// modport master : the issuing/consuming ALU side
// ---------------------------------------------------------------------------
interface addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage,
// latency STAGES = WIDTH/CHUNK cycles, one beat per cycle throughput.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (drops all in-flight beats)
//   bus   : addsub_pipe_if.slave (operand and result handshakes)
// op: 00 ADD, 01 ADC, 10 SUB, 11 SBB. For SUB/SBB cout = 1 means no borrow.
// ---------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_params
            $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    // Per-stage registers. r_a/r_bx carry the not-yet-added upper slices,
    // r_s accumulates finished lower sum slices, r_c is the inter-stage carry.
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_bx  [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_vld [STAGES];
    logic             r_ov;
    logic             r_zero;
    logic             r_neg;

    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_bx_in [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic [WIDTH-1:0] w_s_out [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_v_in  [STAGES];
    logic [CHUNK:0]   w_add   [STAGES];
    logic             w_ov;
    logic             w_stall;

    // Whole pipe freezes while the result sits unaccepted; that keeps the
    // output stable and makes in_ready a single gate.
    assign w_stall = r_vld[STAGES-1] & ~bus.out_ready;

    always_comb begin
        // Stage 0 takes the operands straight from the bus; SUB/SBB invert b
        // so every op becomes a + bx + c0.
        w_a_in[0]  = bus.a;
        w_bx_in[0] = bus.op[1] ? ~bus.b : bus.b;
        w_c_in[0]  = bus.op[0] ? bus.cin : bus.op[1];
        w_s_in[0]  = '0;
        w_v_in[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k]  = r_a[k-1];
            w_bx_in[k] = r_bx[k-1];
            w_c_in[k]  = r_c[k-1];
            w_s_in[k]  = r_s[k-1];
            w_v_in[k]  = r_vld[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_add[k]   = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                       + {1'b0, w_bx_in[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_c_in[k]};
            w_s_out[k] = w_s_in[k];
            w_s_out[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
        // Signed overflow uses the effective operand bx, not raw b.
        w_ov = (w_a_in[STAGES-1][MSB] == w_bx_in[STAGES-1][MSB])
             & (w_s_out[STAGES-1][MSB] != w_a_in[STAGES-1][MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_bx[k]  <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ov   <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_in[k];
                r_a[k]   <= w_a_in[k];
                r_bx[k]  <= w_bx_in[k];
                r_s[k]   <= w_s_out[k];
                r_c[k]   <= w_add[k][CHUNK];
            end
            // Flags are registered alongside the final sum.
            r_ov   <= w_ov;
            r_zero <= ~|w_s_out[STAGES-1];
            r_neg  <= w_s_out[STAGES-1][MSB];
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sum       = r_s[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.overflow  = r_ov;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_neg;
endmodule
